// File: rtl/dma_master_pkg.sv
// Shared types and helpers for the pdp11 device-side DMA initiator.
// Covers the controller states, the bus widths and the word-address arithmetic.
package dma_master_pkg;

  localparam int DMA_AW = 18;
  localparam int DMA_DW = 16;

  localparam logic [DMA_AW-1:0] ALIGN_MASK = 18'h3FFFE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } dma_state_e;

  function automatic logic [DMA_AW-1:0] word_align(input logic [DMA_AW-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  // Physical memory is 18 bits; stepping past 0o777776 wraps silently to 0.
  function automatic logic [DMA_AW-1:0] next_word_addr(input logic [DMA_AW-1:0] a);
    return a + 18'd2;
  endfunction

endpackage

// File: rtl/dma_fifo.sv
// Word FIFO between the memory side and the device side of dma_master.
// Push and pop may happen in the same cycle; flush empties it in one cycle.
module dma_fifo
  import dma_master_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DMA_DW-1:0] push_data,
  input  logic              pop,
  output logic [DMA_DW-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [DMA_DW-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_r <= push ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= pop  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Word storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DMA_DW{1'b0}};
      end
    end else if (push && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == {(AW+1){1'b0}});
  assign count = count_r;

endmodule

// File: rtl/dma_master.sv
// Device-side DMA initiator: requests the pdp11 bus and moves one word per
// granted cycle between the device FIFO and 18-bit physical memory.
module dma_master
  import dma_master_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              dir,
  input  logic [DMA_AW-1:0] start_addr,
  input  logic [DMA_DW-1:0] word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DMA_AW-1:0] cur_addr,
  output logic              dma_req,
  input  logic              dma_ack,
  output logic [DMA_AW-1:0] dma_addr,
  output logic              dma_rd,
  output logic              dma_wr,
  input  logic [DMA_DW-1:0] dma_data_in,
  output logic [DMA_DW-1:0] dma_data_out,
  input  logic [DMA_DW-1:0] dev_wdata,
  input  logic              dev_wvalid,
  output logic              dev_wready,
  output logic [DMA_DW-1:0] dev_rdata,
  output logic              dev_rvalid,
  input  logic              dev_rready
);

  localparam logic [AW:0] FIFO_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};

  dma_state_e        state_r, state_s;
  logic              dir_r, dir_s;
  logic [DMA_DW-1:0] mem_cnt_r, mem_cnt_s;
  logic [DMA_DW-1:0] dev_cnt_r, dev_cnt_s;
  logic [DMA_AW-1:0] dma_addr_r, dma_addr_s;
  logic              dma_req_r, dma_req_s;
  logic              done_r, aborted_r, busy_r;

  logic              fifo_full_s, fifo_empty_s;
  logic [AW:0]       fifo_count_s, fifo_cnt_next_s;
  logic [DMA_DW-1:0] fifo_head_s, push_data_s;
  logic              xfer_s, mem_ok_s, wr_hs_s, rd_hs_s;
  logic              push_s, pop_s, flush_s, mem_step_s, dev_step_s;

  // Strobes are combinational so a grant can move a word in the same cycle.
  assign xfer_s     = (state_r == ST_XFER);
  assign mem_ok_s   = xfer_s & ~abort & dma_ack & (mem_cnt_r != 16'd0);
  assign dma_rd     = mem_ok_s & ~dir_r & ~fifo_full_s;
  assign dma_wr     = mem_ok_s &  dir_r & ~fifo_empty_s;
  assign dev_wready = xfer_s & dir_r & ~fifo_full_s & (dev_cnt_r != 16'd0);
  assign dev_rvalid = ~dir_r & ~fifo_empty_s;

  assign wr_hs_s     = dev_wvalid & dev_wready;
  assign rd_hs_s     = dev_rvalid & dev_rready;
  assign push_s      = dma_rd | wr_hs_s;
  assign pop_s       = dma_wr | rd_hs_s;
  assign push_data_s = dir_r ? dev_wdata : dma_data_in;
  assign flush_s     = (state_r == ST_ABORT);
  assign mem_step_s  = dma_rd | dma_wr;
  assign dev_step_s  = wr_hs_s | rd_hs_s;

  assign dma_data_out = (dir_r & ~fifo_empty_s) ? fifo_head_s : 16'd0;
  assign dev_rdata    = dev_rvalid ? fifo_head_s : 16'd0;

  dma_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Controller next state, transfer counters and address.
  always_comb begin
    state_s    = state_r;
    dir_s      = dir_r;
    mem_cnt_s  = mem_cnt_r;
    dev_cnt_s  = dev_cnt_r;
    dma_addr_s = dma_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          dir_s      = dir;
          mem_cnt_s  = word_count;
          dev_cnt_s  = word_count;
          dma_addr_s = word_align(start_addr);
          state_s    = (word_count == 16'd0) ? ST_DONE : ST_XFER;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (mem_step_s) begin
          mem_cnt_s  = mem_cnt_r - 16'd1;
          dma_addr_s = next_word_addr(dma_addr_r);
        end else begin
          mem_cnt_s  = mem_cnt_r;
          dma_addr_s = dma_addr_r;
        end
        if (dev_step_s) begin
          dev_cnt_s = dev_cnt_r - 16'd1;
        end else begin
          dev_cnt_s = dev_cnt_r;
        end
        if (abort) begin
          state_s = ST_ABORT;
        end else if ((mem_cnt_r == 16'd0) && (dev_cnt_r == 16'd0)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_DONE:  state_s = abort ? ST_ABORT : ST_IDLE;
      ST_ABORT: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Request looks at post-update counts so it never asks for a grant it cannot use.
  always_comb begin
    fifo_cnt_next_s = fifo_count_s;
    dma_req_s       = 1'b0;
    if (flush_s) begin
      fifo_cnt_next_s = {(AW+1){1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_next_s = fifo_count_s + CNT_ONE;
        2'b01:   fifo_cnt_next_s = fifo_count_s - CNT_ONE;
        default: fifo_cnt_next_s = fifo_count_s;
      endcase
    end
    if ((state_s == ST_XFER) && (mem_cnt_s != 16'd0)) begin
      dma_req_s = dir_s ? (fifo_cnt_next_s != {(AW+1){1'b0}})
                        : (fifo_cnt_next_s != FIFO_FULL);
    end else begin
      dma_req_s = 1'b0;
    end
  end

  // Controller registers and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      dir_r      <= 1'b0;
      mem_cnt_r  <= 16'd0;
      dev_cnt_r  <= 16'd0;
      dma_addr_r <= 18'd0;
      dma_req_r  <= 1'b0;
      done_r     <= 1'b0;
      aborted_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      dir_r      <= dir_s;
      mem_cnt_r  <= mem_cnt_s;
      dev_cnt_r  <= dev_cnt_s;
      dma_addr_r <= dma_addr_s;
      dma_req_r  <= dma_req_s;
      done_r     <= (state_r == ST_DONE) && (state_s == ST_IDLE);
      aborted_r  <= (state_s == ST_ABORT);
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign aborted  = aborted_r;
  assign dma_req  = dma_req_r;
  assign dma_addr = dma_addr_r;
  assign cur_addr = dma_addr_r;

endmodule

// File: tb/tb_dma_master.sv
// Scoreboard bench for dma_master: arbiter, memory and device models drive the
// block, expected addresses/data are queued at stimulus time and popped on output.
module tb_dma_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, dir = 1'b0, abort = 1'b0;
  logic [17:0] start_addr = 18'd0;
  logic [15:0] word_count = 16'd0;
  logic        busy, done, aborted, dma_req, dma_rd, dma_wr;
  logic [17:0] cur_addr, dma_addr;
  logic        dma_ack = 1'b0;
  logic [15:0] dma_data_in, dma_data_out, dev_rdata;
  logic [15:0] dev_wdata = 16'd0;
  logic        dev_wvalid = 1'b0, dev_wready, dev_rvalid;
  logic        dev_rready = 1'b0;

  logic        arb_en = 1'b0, ack_all = 1'b0, mon_en = 1'b0, wr_hs = 1'b0;
  int          n_total = 0, n_bad = 0;
  int          n_req = 0, n_done = 0, n_abort = 0, n_rd = 0, n_wr = 0, n_idle_ack = 0;
  int          arb_run = 0, wr_idx = 0;
  logic [15:0] wr_words[$];
  logic [31:0] exp_addr_q[$], exp_rdata_q[$], exp_wdata_q[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [17:0] a);
    return a[16:1] ^ 16'hC35A;
  endfunction

  assign dma_data_in = mem_word(dma_addr);

  dma_master #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dir(dir), .start_addr(start_addr),
    .word_count(word_count), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .cur_addr(cur_addr), .dma_req(dma_req), .dma_ack(dma_ack), .dma_addr(dma_addr),
    .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_data_in(dma_data_in), .dma_data_out(dma_data_out),
    .dev_wdata(dev_wdata), .dev_wvalid(dev_wvalid), .dev_wready(dev_wready),
    .dev_rdata(dev_rdata), .dev_rvalid(dev_rvalid), .dev_rready(dev_rready)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Output monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    if (mon_en) begin
      if (dma_req) n_req++;
      if (done) n_done++;
      if (aborted) n_abort++;
      if (dma_ack && !dma_rd && !dma_wr && busy) n_idle_ack++;
      if (dma_rd || dma_wr) begin
        if (dma_rd) n_rd++;
        if (dma_wr) n_wr++;
        e = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
        check_val("mem_addr", 32'(dma_addr), e);
      end
      if (dma_wr) begin
        e = (exp_wdata_q.size() != 0) ? exp_wdata_q.pop_front() : 32'hFFFF_FFFF;
        check_val("wr_data", 32'(dma_data_out), e);
      end
      if (dev_rvalid && dev_rready) begin
        e = (exp_rdata_q.size() != 0) ? exp_rdata_q.pop_front() : 32'hFFFF_FFFF;
        check_val("dev_rdata", 32'(dev_rdata), e);
      end
      if (dev_wvalid && dev_wready) begin
        exp_wdata_q.push_back(32'(dev_wdata));
        wr_hs = 1'b1;
      end else begin
        wr_hs = 1'b0;
      end
    end else begin
      wr_hs = 1'b0;
    end
  end

  // Arbiter (runs of up to 3 grants) and device write-side model.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ack_all) begin
        dma_ack = 1'b1;
      end else if (arb_en && dma_req && arb_run < 3) begin
        dma_ack = 1'b1;
        arb_run++;
      end else begin
        dma_ack = 1'b0;
        arb_run = 0;
      end
      if (wr_hs) wr_idx++;
      if (wr_idx < wr_words.size()) begin
        dev_wvalid = 1'b1;
        dev_wdata  = wr_words[wr_idx];
      end else begin
        dev_wvalid = 1'b0;
        dev_wdata  = 16'd0;
      end
    end
  end

  task automatic reset_counts();
    n_req = 0; n_done = 0; n_abort = 0; n_rd = 0; n_wr = 0; n_idle_ack = 0;
  endtask

  task automatic start_xfer(input logic d, input logic [17:0] a, input logic [15:0] n, input int n_exp);
    logic [17:0] ea;
    ea = a;
    for (int k = 0; k < n_exp; k++) begin
      exp_addr_q.push_back(32'(ea));
      if (!d) exp_rdata_q.push_back(32'(mem_word(ea)));
      ea = ea + 18'd2;
    end
    @(posedge clk); #1;
    dir = d; start_addr = a; word_count = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, input logic exp_done);
    int i;
    i = 0;
    while (i < budget) begin
      @(negedge clk);
      if (!busy) break;
      i++;
    end
    check_val({tag, "_timeout"}, 32'(i < budget), 32'd1);
    check_val({tag, "_done"}, 32'(done), 32'(exp_done));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    int seen, k;
    // reset state
    #3;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_req", 32'(dma_req), 32'd0);
    check_val("rst_addr", 32'(dma_addr), 32'd0);
    check_val("rst_wready", 32'(dev_wready), 32'd0);
    check_val("rst_rvalid", 32'(dev_rvalid), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: reset mid-transfer
    arb_en = 1'b1; dev_rready = 1'b0;
    start_xfer(1'b0, 18'o500, 16'd8, 0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_val("t1_busy", 32'(busy), 32'd0);
    check_val("t1_req", 32'(dma_req), 32'd0);
    check_val("t1_rd", 32'(dma_rd), 32'd0);
    check_val("t1_rvalid", 32'(dev_rvalid), 32'd0);
    check_val("t1_addr", 32'(cur_addr), 32'd0);
    check_val("t1_done", 32'(done), 32'd0);
    #10 reset_n = 1'b1;
    @(negedge clk);
    exp_addr_q.delete(); exp_rdata_q.delete(); exp_wdata_q.delete();
    reset_counts();
    mon_en = 1'b1;

    // 2: mem->dev, 5 words from 0o1000
    dev_rready = 1'b1;
    start_xfer(1'b0, 18'o1000, 16'd5, 5);
    wait_idle("t2", 200, 1'b1);
    check_val("t2_nrd", 32'(n_rd), 32'd5);
    check_val("t2_q", 32'(exp_addr_q.size() + exp_rdata_q.size()), 32'd0);
    check_val("t2_cur", 32'(cur_addr), 32'(18'o1012));
    check_val("t2_ndone", 32'(n_done), 32'd1);

    // 3: dev->mem, 4 words to 0o2000 (fifth offered word must never be taken)
    reset_counts();
    wr_words = '{16'o111, 16'o222, 16'o333, 16'o444, 16'o555};
    wr_idx = 0;
    start_xfer(1'b1, 18'o2000, 16'd4, 4);
    wait_idle("t3", 200, 1'b1);
    check_val("t3_nwr", 32'(n_wr), 32'd4);
    check_val("t3_widx", 32'(wr_idx), 32'd4);
    check_val("t3_wready", 32'(dev_wready), 32'd0);
    check_val("t3_q", 32'(exp_addr_q.size() + exp_wdata_q.size()), 32'd0);
    check_val("t3_ndone", 32'(n_done), 32'd1);
    wr_words.delete(); wr_idx = 0;
    @(negedge clk);

    // 4: zero-length transfer
    reset_counts();
    start_xfer(1'b0, 18'o4000, 16'd0, 0);
    @(negedge clk);
    check_val("t4_busy1", 32'(busy), 32'd1);
    check_val("t4_done1", 32'(done), 32'd0);
    @(negedge clk);
    check_val("t4_done2", 32'(done), 32'd1);
    check_val("t4_busy2", 32'(busy), 32'd0);
    @(negedge clk);
    check_val("t4_nreq", 32'(n_req), 32'd0);
    check_val("t4_ndone", 32'(n_done), 32'd1);

    // 5a: address wrap
    reset_counts();
    start_xfer(1'b0, 18'o777776, 16'd2, 2);
    wait_idle("t5a", 200, 1'b1);
    check_val("t5a_nrd", 32'(n_rd), 32'd2);
    check_val("t5a_cur", 32'(cur_addr), 32'd2);
    check_val("t5a_q", 32'(exp_addr_q.size() + exp_rdata_q.size()), 32'd0);

    // 5b: FIFO fills with device stalled, grants then move nothing
    reset_counts();
    dev_rready = 1'b0; ack_all = 1'b1;
    start_xfer(1'b0, 18'd0, 16'd6, 6);
    repeat (12) @(negedge clk);
    check_val("t5b_nrd", 32'(n_rd), 32'd4);
    check_val("t5b_idle_ack", 32'(n_idle_ack != 0), 32'd1);
    check_val("t5b_req", 32'(dma_req), 32'd0);
    check_val("t5b_rvalid", 32'(dev_rvalid), 32'd1);
    @(posedge clk); #1;
    ack_all = 1'b0; dev_rready = 1'b1;
    wait_idle("t5b", 200, 1'b1);
    check_val("t5b_nrd_end", 32'(n_rd), 32'd6);
    check_val("t5b_q", 32'(exp_addr_q.size() + exp_rdata_q.size()), 32'd0);

    // 6: abort in the second grant cycle
    reset_counts();
    start_xfer(1'b0, 18'o3000, 16'd8, 8);
    #1;
    seen = 0; k = 0;
    while (k < 50) begin
      if (dma_ack) begin
        seen++;
        if (seen == 2) break;
      end
      @(posedge clk); #2;
      k++;
    end
    check_val("t6_grant2", 32'(seen), 32'd2);
    abort = 1'b1;
    #2;
    check_val("t6_ack", 32'(dma_ack), 32'd1);
    check_val("t6_no_rd", 32'(dma_rd), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    #1;
    check_val("t6_req", 32'(dma_req), 32'd0);
    check_val("t6_aborted", 32'(aborted), 32'd1);
    @(posedge clk); #2;
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_flushed", 32'(dev_rvalid), 32'd0);
    @(negedge clk);
    check_val("t6_nrd", 32'(n_rd), 32'd1);
    check_val("t6_ndone", 32'(n_done), 32'd0);
    check_val("t6_nabort", 32'(n_abort), 32'd1);
    mon_en = 1'b0;
    exp_addr_q.delete(); exp_rdata_q.delete();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
